// File: rtl/accum_seq.sv
// Sums the eight FMULT products of one sample into SEZ (six zero-section terms) and SE (all eight terms).
// out_valid pulses one cycle after WA1 is accepted; no backpressure, so every valid term is consumed.
module accum_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] wan,
  input  logic        wan_valid,
  input  logic        wan_first,
  output logic [14:0] sez,
  output logic [14:0] se,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ZERO, POLE, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] sez_d, se_d;
  logic [15:0] sum;
  logic        start;

  // Modulo-2^16 running sum; carry out is deliberately dropped.
  assign sum   = acc_q + wan;
  assign start = wan_valid & wan_first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sez     <= '0;
      se      <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sez     <= sez_d;
      se      <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sez_d   = sez;
    se_d    = se;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ZERO;
          acc_d   = wan;
          cnt_d   = 4'd1;
        end
      end
      ZERO: begin
        if (start) begin
          acc_d = wan;
          cnt_d = 4'd1;
        end else if (wan_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            sez_d   = sum[15:1];
            state_d = POLE;
          end
        end
      end
      POLE: begin
        if (start) begin
          state_d = ZERO;
          acc_d   = wan;
          cnt_d   = 4'd1;
        end else if (wan_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 4'd1;
          // cnt 7 means WA2 already taken, so this term is WA1.
          if (cnt_q == 4'd7) begin
            se_d    = sum[15:1];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = ZERO;
          acc_d   = wan;
          cnt_d   = 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ZERO) || (state_q == POLE);

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq: per-cycle comparison against a term-counting model plus literal checks.
module tb_accum_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] wan;
  logic        wan_valid;
  logic        wan_first;
  logic [14:0] sez;
  logic [14:0] se;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // Model state: which term of the sample we are on and its running sum.
  bit          m_active;
  int          m_n;
  logic [15:0] m_sum;
  logic [14:0] m_sez, m_se;
  bit          m_ov;

  accum_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wan       (wan),
    .wan_valid (wan_valid),
    .wan_first (wan_first),
    .sez       (sez),
    .se        (se),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_n      = 0;
      m_sum    = '0;
      m_sez    = '0;
      m_se     = '0;
      m_ov     = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (wan_valid && wan_first) begin
        m_active = 1'b1;
        m_n      = 1;
        m_sum    = wan;
      end else if (wan_valid && m_active) begin
        m_sum = m_sum + wan;
        m_n++;
        if (m_n == 6) m_sez = m_sum[15:1];
        if (m_n == 8) begin
          m_se     = m_sum[15:1];
          m_active = 1'b0;
          m_ov     = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      check("cyc_sez", sez, m_sez);
      check("cyc_se", se, m_se);
      check("cyc_out_valid", out_valid, m_ov);
      check("cyc_busy", busy, m_active);
      if (out_valid) pulses++;
    end
  end

  task automatic drive(input logic [15:0] w, input bit f);
    wan       = w;
    wan_valid = 1'b1;
    wan_first = f;
    @(negedge clk);
    wan_valid = 1'b0;
    wan_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    wan       = '0;
    wan_valid = 1'b0;
    wan_first = 1'b0;
    #1;
    check("rst_sez", sez, 15'h0);
    check("rst_se", se, 15'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    idle(2);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    idle(1);

    // A term without wan_first while idle must not start a sample.
    drive(16'h1234, 1'b0);
    check("idle_ignore_busy", busy, 1'b0);

    // Basic sum of ones.
    pulses = 0;
    drive(16'h0001, 1'b1);
    check("t1_busy", busy, 1'b1);
    repeat (7) drive(16'h0001, 1'b0);
    check("t1_ov_latency", out_valid, 1'b1);
    check("t1_busy_done", busy, 1'b0);
    idle(1);
    check("t1_ov_single", out_valid, 1'b0);
    idle(2);
    check("t1_sez", sez, 15'h0003);
    check("t1_se", se, 15'h0004);
    check("t1_pulses", pulses, 1);

    // Negative products.
    pulses = 0;
    drive(16'hFFFF, 1'b1);
    repeat (5) drive(16'hFFFF, 1'b0);
    check("t2_sez_early", sez, 15'h7FFD);
    check("t2_se_held", se, 15'h0004);
    drive(16'hFFFE, 1'b0);
    drive(16'h0000, 1'b0);
    idle(2);
    check("t2_sez", sez, 15'h7FFD);
    check("t2_se", se, 15'h7FFC);
    check("t2_pulses", pulses, 1);

    // Wrap-around without saturation.
    pulses = 0;
    drive(16'h4000, 1'b1);
    repeat (7) drive(16'h4000, 1'b0);
    idle(2);
    check("t3_sez", sez, 15'h4000);
    check("t3_se", se, 15'h0000);
    check("t3_pulses", pulses, 1);

    // Abort after three terms, then a gapped sample of twos.
    pulses = 0;
    drive(16'h0007, 1'b1);
    repeat (2) drive(16'h0007, 1'b0);
    drive(16'h0002, 1'b1);
    check("t4_sez_held", sez, 15'h4000);
    repeat (7) begin
      idle($urandom_range(0, 2));
      drive(16'h0002, 1'b0);
    end
    idle(2);
    check("t4_sez", sez, 15'h0006);
    check("t4_se", se, 15'h0008);
    check("t4_pulses", pulses, 1);

    // Back-to-back: second sample starts in the DONE cycle.
    pulses = 0;
    drive(16'h0003, 1'b1);
    repeat (7) drive(16'h0003, 1'b0);
    check("t5_ov_a", out_valid, 1'b1);
    check("t5_se_a", se, 15'h000C);
    check("t5_sez_a", sez, 15'h0009);
    drive(16'h0005, 1'b1);
    check("t5_busy_b", busy, 1'b1);
    repeat (7) drive(16'h0005, 1'b0);
    idle(2);
    check("t5_sez_b", sez, 15'h000F);
    check("t5_se_b", se, 15'h0014);
    check("t5_pulses", pulses, 2);

    // Asynchronous reset mid-sample discards the partial sum.
    drive(16'h0009, 1'b1);
    repeat (2) drive(16'h0009, 1'b0);
    #2;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_rst_sez", sez, 15'h0);
    check("t6_rst_se", se, 15'h0);
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (3) drive(16'h0001, 1'b0);
    check("t6_no_start", busy, 1'b0);
    pulses = 0;
    drive(16'h0001, 1'b1);
    repeat (7) drive(16'h0001, 1'b0);
    idle(2);
    check("t6_sez", sez, 15'h0003);
    check("t6_se", se, 15'h0004);
    check("t6_pulses", pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_seq.md
ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The clk port SHALL be an input, 1 bit wide; it is the system clock, and all state updates on its rising edge.
REQ-003 The reset_n port SHALL be an input, 1 bit wide; asynchronous active-low reset.
REQ-004 The wan port SHALL be an input, 16 bits wide; one FMULT product (WBn or WAn), 16-bit two's complement.
REQ-005 The wan_valid port SHALL be an input, 1 bit wide; wan is presented this cycle.
REQ-006 The wan_first port SHALL be an input, 1 bit wide; qualified by wan_valid, it marks the product as term 0 (WB1) of a new sample.
REQ-007 The sez port SHALL be an output, 15 bits wide; the zero-section estimate SEZ.
REQ-008 The se port SHALL be an output, 15 bits wide; the signal estimate SE.
REQ-009 The out_valid port SHALL be an output, 1 bit wide; a one-cycle pulse when sez and se are updated.
REQ-010 The busy port SHALL be an output, 1 bit wide; high while a sample's accumulation is in progress.

Function
REQ-011 The block SHALL accept exactly 8 products per sample, in this fixed order: WB1, WB2, WB3, WB4, WB5, WB6, WA2, WA1.
REQ-012 A product SHALL be accepted on a rising clk edge where wan_valid=1; there is no backpressure, so every valid term is consumed.
REQ-013 The FSM SHALL have the states IDLE, ZERO, POLE and DONE.
REQ-014 IDLE: on wan_valid & wan_first, go to ZERO and set acc=wan, cnt=1; a valid term without wan_first is ignored.
REQ-015 ZERO: each valid term sets acc=acc+wan and cnt=cnt+1; when the 6th term (cnt becomes 6) is accepted, register sez=(acc+wan)>>>1 and go to POLE.
REQ-016 POLE: accept WA2 and then WA1; when WA1 is accepted, register se=(acc+wan)>>>1, assert out_valid on the next cycle, and go to DONE.
REQ-017 DONE: lasts one cycle with out_valid=1, then returns to IDLE; a term presented in this cycle with wan_first=1 SHALL start a new sample (go to ZERO), so back-to-back samples are supported.
REQ-018 In ZERO or POLE, wan_valid & wan_first SHALL abort the current sample without updating sez or se, and restart with acc=wan and cnt=1.
REQ-019 All additions SHALL be 16-bit modulo 2^16, with no saturation and the carry discarded.
REQ-020 sez and se SHALL be bits [15:1] of the 16-bit sum, i.e. an arithmetic shift right by 1, truncated to 15 bits.
REQ-021 If wan_valid=0, acc, cnt, state, sez and se SHALL hold.
REQ-022 sez SHALL update only at the ZERO->POLE transition, and se only when WA1 is accepted; both hold otherwise.
REQ-023 Latency SHALL be: out_valid rises 1 cycle after the edge accepting WA1, with se and sez stable in that cycle.
REQ-024 busy SHALL be 1 in ZERO and POLE and 0 in IDLE and DONE.

Reset
REQ-025 While reset_n=0, the block SHALL force state=IDLE, acc=0, cnt=0, sez=0, se=0, out_valid=0 and busy=0.
REQ-026 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-027 Reset asserted mid-sample SHALL discard the partial sum; after release, only a term with wan_first=1 starts accumulation.

Verification
REQ-028 Reset check: assert reset_n=0 at any point -> sez=0, se=0, out_valid=0 and busy=0 with no clock edge required.
REQ-029 Basic sum: 8 terms of 0x0001, first term flagged -> sez=0x0003, se=0x0004, a single out_valid pulse 1 cycle after the 8th term.
REQ-030 Negative values: six terms of 0xFFFF, then WA2=0xFFFE, then WA1=0x0000 -> sez=0x7FFD (-3), se=0x7FFC (-4).
REQ-031 Wrap-around: 8 terms of 0x4000 -> sez=0x4000 (sum 0x8000>>>1) and se=0x0000, with no saturation.
REQ-032 Abort and gaps: start a sample, send 3 terms, then send wan_first with a new sample of 8 terms of 0x0002, with random wan_valid=0 gaps -> exactly one out_valid, sez=0x0006, se=0x0008.
REQ-033 Back-to-back: a second sample's wan_first arrives in the DONE cycle -> both samples produce correct se values and two out_valid pulses, with no term lost.
